freq_meter: RTL and testbench

- Reciprocal of the board clock divider: measures the frequency of an external or divided square-wave signal by counting its rising edges over a fixed gate window of clki cycles.
- Gate window defaults to 1 s at 50 MHz, so the reading is in Hz.
- Sits beside the clock divider, for example to self-check clk_hz and clk_khz or to measure a pin. It feeds the display driver.

---
 rtl/freq_meter_pkg.sv | 15 +
 rtl/freq_meter_sig_sync_edge.sv | 34 +++
 rtl/freq_meter.sv | 110 +++++++++++
 tb/tb_freq_meter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants and state encoding for the frequency meter and its
// neighbour, the clock divider.
package freq_meter_pkg;

  localparam int unsigned DEF_GATE_CYCLES = 50000000;
  localparam int unsigned DEF_CW          = 27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/freq_meter_sig_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, followed by an edge flop
// that yields a one-cycle pulse on each synchronized rising edge.
module sig_sync_edge (
  input  logic clki,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over a window
// of GATE_CYCLES clki cycles and publishes the count on freq.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CW          = DEF_CW
) (
  input  logic          clki,
  input  logic          rst,
  input  logic          sig_in,
  input  logic          start,
  input  logic          cont,
  output logic [CW-1:0] freq,
  output logic          freq_valid,
  output logic          overflow,
  output logic          busy
);

  localparam int unsigned GW = $clog2(GATE_CYCLES);

  logic rise;

  state_e        state_q, state_d;
  logic [GW-1:0] gate_cnt_q, gate_cnt_d;
  logic [CW-1:0] edge_cnt_q, edge_cnt_d;
  logic          ovf_int_q, ovf_int_d;
  logic [CW-1:0] freq_q, freq_d;
  logic          overflow_q, overflow_d;
  logic          freq_valid_q, freq_valid_d;
  logic          busy_q, busy_d;

  sig_sync_edge u_sync (
    .clki (clki),
    .rst  (rst),
    .d    (sig_in),
    .rise (rise)
  );

  // Next state, counters and result capture.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_int_d  = ovf_int_q;
    freq_d     = freq_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start || cont) state_d = ST_ARM;
      end
      ST_ARM: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_int_d  = 1'b0;
        state_d    = ST_GATE;
      end
      ST_GATE: begin
        gate_cnt_d = gate_cnt_q + GW'(1);
        if (rise) begin
          if (edge_cnt_q == {CW{1'b1}}) ovf_int_d = 1'b1;
          else                          edge_cnt_d = edge_cnt_q + CW'(1);
        end
        // Result is captured on entry to DONE so freq is already valid
        // during the freq_valid cycle; the final-cycle rise is included.
        if (gate_cnt_q == GW'(GATE_CYCLES - 1)) begin
          state_d    = ST_DONE;
          freq_d     = edge_cnt_d;
          overflow_d = ovf_int_d;
        end
      end
      ST_DONE: begin
        state_d = cont ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    freq_valid_d = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_int_q    <= 1'b0;
      freq_q       <= '0;
      overflow_q   <= 1'b0;
      freq_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_int_q    <= ovf_int_d;
      freq_q       <= freq_d;
      overflow_q   <= overflow_d;
      freq_valid_q <= freq_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign freq       = freq_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a wide instance and a 4-bit saturating
// instance share all inputs and are checked against hand-computed readings.
module tb_freq_meter;

  localparam int unsigned GATE = 1000;
  localparam int unsigned LAT  = GATE + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, cont, sig_in;
  logic [26:0] freq;
  logic        freq_valid, overflow, busy;
  logic [3:0]  sat_freq;
  logic        sat_valid, sat_ovf, sat_busy;

  freq_meter #(.GATE_CYCLES(GATE), .CW(27)) dut (
    .clki(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .freq(freq), .freq_valid(freq_valid), .overflow(overflow), .busy(busy)
  );

  freq_meter #(.GATE_CYCLES(GATE), .CW(4)) dut_sat (
    .clki(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .freq(sat_freq), .freq_valid(sat_valid), .overflow(sat_ovf), .busy(sat_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Square-wave generator: period 0 holds sig_level, else 50% duty.
  int   sig_period = 0;
  logic sig_level  = 1'b0;
  initial begin
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (sig_period == 0) begin
        sig_in = sig_level;
        ph = 0;
      end else begin
        if (ph == 0) sig_in = 1'b1;
        else if (ph == sig_period / 2) sig_in = 1'b0;
        ph = (ph + 1 >= sig_period) ? 0 : ph + 1;
      end
    end
  end

  task automatic settle(input int period, input logic level);
    sig_period = period;
    sig_level  = level;
    repeat (250) @(negedge clk);
  endtask

  // Cycles until the next freq_valid, optionally raising start for one cycle.
  task automatic wait_valid(input logic do_start, output int n);
    start = do_start;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
    end while (!freq_valid && n < 3 * LAT);
  endtask

  task automatic run(input int cyc, output int pulses);
    pulses = 0;
    repeat (cyc) begin
      @(posedge clk);
      @(negedge clk);
      if (freq_valid) pulses++;
    end
  endtask

  typedef struct {
    int   period;
    logic level;
    int   exp_freq;
    int   exp_sat;
    logic exp_sat_ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n, p;

    vecs[0] = '{period: 10,  level: 1'b0, exp_freq: 100, exp_sat: 15, exp_sat_ovf: 1'b1};
    vecs[1] = '{period: 0,   level: 1'b1, exp_freq: 0,   exp_sat: 0,  exp_sat_ovf: 1'b0};
    vecs[2] = '{period: 0,   level: 1'b0, exp_freq: 0,   exp_sat: 0,  exp_sat_ovf: 1'b0};
    vecs[3] = '{period: 100, level: 1'b0, exp_freq: 10,  exp_sat: 10, exp_sat_ovf: 1'b0};
    vecs[4] = '{period: 8,   level: 1'b0, exp_freq: 125, exp_sat: 15, exp_sat_ovf: 1'b1};

    rst = 1'b1; start = 1'b0; cont = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_freq", freq, 0);
    check("rst_valid", freq_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_sat_busy", sat_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // One-shot measurements
    for (int i = 0; i < 5; i++) begin
      settle(vecs[i].period, vecs[i].level);
      wait_valid(1'b1, n);
      check($sformatf("v%0d_latency", i), n, LAT);
      check($sformatf("v%0d_freq", i), freq, vecs[i].exp_freq);
      check($sformatf("v%0d_ovf", i), overflow, 0);
      check($sformatf("v%0d_busy_done", i), busy, 1);
      check($sformatf("v%0d_sat_valid", i), sat_valid, 1);
      check($sformatf("v%0d_sat_freq", i), sat_freq, vecs[i].exp_sat);
      check($sformatf("v%0d_sat_ovf", i), sat_ovf, vecs[i].exp_sat_ovf);
      run(1, p);
      check($sformatf("v%0d_busy_after", i), busy, 0);
      check($sformatf("v%0d_valid_after", i), freq_valid, 0);
      check($sformatf("v%0d_freq_hold", i), freq, vecs[i].exp_freq);
      check($sformatf("v%0d_sat_ovf_hold", i), sat_ovf, vecs[i].exp_sat_ovf);
    end

    // Continuous mode, then drop cont mid-gate
    settle(20, 1'b0);
    cont = 1'b1;
    wait_valid(1'b0, n);
    check("cont_first_freq", freq, 50);
    for (int k = 0; k < 3; k++) begin
      wait_valid(1'b0, n);
      check($sformatf("cont%0d_period", k), n, LAT);
      check($sformatf("cont%0d_freq", k), freq, 50);
    end
    run(500, p);
    cont = 1'b0;
    run(2 * LAT, p);
    check("cont_drop_pulses", p, 1);
    check("cont_drop_busy", busy, 0);

    // Reset in the middle of the gate window
    settle(10, 1'b0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    run(501, p);
    check("rstgate_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstgate_freq", freq, 0);
    check("rstgate_busy", busy, 0);
    check("rstgate_valid", freq_valid, 0);
    rst = 1'b0;
    run(1500, p);
    check("rstgate_no_pulse", p, 0);
    wait_valid(1'b1, n);
    check("rstgate_remeasure_lat", n, LAT);
    check("rstgate_remeasure_freq", freq, 100);

    // start pulses while busy and on the DONE cycle are ignored
    run(5, p);
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == 100 || n == 600) ? 1'b1 : 1'b0;
    end while (!freq_valid && n < 3 * LAT);
    check("busy_start_latency", n, LAT);
    check("busy_start_freq", freq, 100);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("done_start_busy", busy, 0);
    run(1500, p);
    check("done_start_no_pulse", p, 0);
    check("done_start_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
